// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM states and {cpol,cpha} mode encodings.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold
    } spi_state_e;

    localparam logic [1:0] Mode0 = 2'b00;
    localparam logic [1:0] Mode1 = 2'b01;
    localparam logic [1:0] Mode2 = 2'b10;
    localparam logic [1:0] Mode3 = 2'b11;

    // CPHA=0 modes sample on the leading SCLK edge, CPHA=1 modes on the trailing one.
    function automatic logic samples_on_leading(input logic [1:0] mode);
        return (mode == Mode0) || (mode == Mode2);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: counts ClkDiv clk cycles per tick and numbers the SCLK edges.
module spi_clk_div #(
    parameter int unsigned ClkDiv = 4,
    parameter int unsigned EdgeW  = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             edge_en_i,
    output logic             tick_o,
    output logic [EdgeW-1:0] edge_idx_o
);

    localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [EdgeW-1:0] edge_q, edge_d;

    assign tick_o     = en_i && (cnt_q == CntW'(ClkDiv - 1));
    assign edge_idx_o = edge_q;

    always_comb begin
        cnt_d  = cnt_q;
        edge_d = edge_q;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Edge index counts completed SCLK edges; it only runs while edges are being produced.
        if (!edge_en_i) begin
            edge_d = '0;
        end else if (tick_o) begin
            edge_d = edge_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            edge_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: DATA_W-bit words, CLK_DIV divider, modes 0-3, NUM_CS selects.
// Optional build macro SPI_LSB_FIRST_EN adds a per-transfer lsb_first input.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_CS  = 4,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);

    spi_state_e        state_q, state_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [1:0]        mode_q, mode_d;
    logic              lsb_q, lsb_d;

    logic              lsb_start;
    logic [DATA_W-1:0] tx_load;
    logic [DATA_W-1:0] rx_final;
    logic [NUM_CS-1:0] cs_dec;
    logic              tick;
    logic [EdgeW-1:0]  edge_idx;
    logic              leading;
    logic              last_edge;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_start = lsb_first;
`else
    assign lsb_start = 1'b0;
`endif

    spi_clk_div #(
        .ClkDiv (CLK_DIV),
        .EdgeW  (EdgeW)
    ) u_clk_div (
        .clk_i      (clk),
        .rst_ni     (rst),
        .en_i       (state_q != StIdle),
        .edge_en_i  (state_q == StXfer),
        .tick_o     (tick),
        .edge_idx_o (edge_idx)
    );

    // Edge number is edge_idx+1; odd numbers are leading edges.
    assign leading   = ~edge_idx[0];
    assign last_edge = (edge_idx == EdgeW'(2 * DATA_W - 1));

    // LSB-first is handled by bit-reversing on load and unload, so the shifter is always MSB-first.
    always_comb begin
        tx_load  = tx_data;
        rx_final = rx_sr_q;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (lsb_start) begin
                tx_load[i] = tx_data[DATA_W-1-i];
            end
            if (lsb_q) begin
                rx_final[i] = rx_sr_q[DATA_W-1-i];
            end
        end
    end

    // Out-of-range selects decode to no active chip select.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < int'(NUM_CS); i++) begin
            if (32'(cs_sel) == 32'(i)) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        mode_d    = mode_q;
        lsb_d     = lsb_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = {cpol, cpha};
                    lsb_d   = lsb_start;
                    sclk_d  = cpol;
                    cs_n_d  = cs_dec;
                    rx_sr_d = '0;
                    state_d = StSetup;
                    // CPHA=0 presents the first bit during setup; CPHA=1 drives it on edge 1.
                    if (samples_on_leading({cpol, cpha})) begin
                        mosi_d  = tx_load[DATA_W-1];
                        tx_sr_d = {tx_load[DATA_W-2:0], 1'b0};
                    end else begin
                        tx_sr_d = tx_load;
                    end
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (leading == samples_on_leading(mode_q)) begin
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                    end else if (!last_edge) begin
                        mosi_d  = tx_sr_q[DATA_W-1];
                        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                    end
                    if (last_edge) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    cs_n_d    = '1;
                    rx_data_d = rx_final;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            mode_q    <= Mode0;
            lsb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            mode_q    <= mode_d;
            lsb_q     <= lsb_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign rx_data = rx_data_q;
    assign done    = done_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_spi_master_param.sv
// Directed self-checking bench for spi_master_param: an 8-bit/CLK_DIV=2 instance and a
// 16-bit/CLK_DIV=1 instance, with loopback and a mode-3 slave model on the first.
module tb_spi_master_param;
    import spi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: DATA_W=8, NUM_CS=4, CLK_DIV=2
    logic       start_a;
    logic [7:0] tx_a;
    logic [1:0] cs_a;
    logic       cpol_a, cpha_a, miso_a;
    logic       sclk_a, mosi_a, busy_a, done_a;
    logic [3:0] cs_n_a;
    logic [7:0] rx_a;
`ifdef SPI_LSB_FIRST_EN
    logic       lsb_a;
    logic       lsb_b;
`endif

    // Instance B: DATA_W=16, NUM_CS=2, CLK_DIV=1, widened cs_sel to reach index 3
    logic        start_b;
    logic [15:0] tx_b;
    logic [1:0]  cs_b;
    logic        cpol_b, cpha_b;
    logic        sclk_b, mosi_b, busy_b, done_b;
    logic [1:0]  cs_n_b;
    logic [15:0] rx_b;

    spi_master_param #(
        .DATA_W  (8),
        .NUM_CS  (4),
        .CLK_DIV (2)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .tx_data   (tx_a),
        .cs_sel    (cs_a),
        .cpol      (cpol_a),
        .cpha      (cpha_a),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first (lsb_a),
`endif
        .miso      (miso_a),
        .sclk      (sclk_a),
        .mosi      (mosi_a),
        .cs_n      (cs_n_a),
        .rx_data   (rx_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    spi_master_param #(
        .DATA_W  (16),
        .NUM_CS  (2),
        .CLK_DIV (1),
        .CS_W    (2)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .tx_data   (tx_b),
        .cs_sel    (cs_b),
        .cpol      (cpol_b),
        .cpha      (cpha_b),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first (lsb_b),
`endif
        .miso      (mosi_b),
        .sclk      (sclk_b),
        .mosi      (mosi_b),
        .cs_n      (cs_n_b),
        .rx_data   (rx_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    // Mode-3 slave on cs_n[1]: shifts out slv_word MSB first on each falling (leading) edge.
    logic       slave_en = 1'b0;
    logic       slv_miso = 1'b0;
    logic [7:0] slv_word = 8'hC3;
    int         slv_cnt  = 0;

    always @(negedge sclk_a or posedge cs_n_a[1]) begin
        if (cs_n_a[1]) begin
            slv_cnt <= 0;
        end else if (slave_en && slv_cnt < 8) begin
            slv_miso <= slv_word[7 - slv_cnt];
            slv_cnt  <= slv_cnt + 1;
        end
    end

    assign miso_a = slave_en ? slv_miso : mosi_a;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int         poke_at = 0;
    logic       b2b = 1'b0;
    logic [7:0] b2b_tx = 8'h00;
    logic [1:0] b2b_mode = 2'b00;
    logic [3:0] cs_exp = 4'b1101;
    int         cs_bad = 0;

    task automatic launch_a(input logic [7:0] d, input logic [1:0] cs, input logic [1:0] mode);
        @(negedge clk);
        tx_a             = d;
        cs_a             = cs;
        {cpol_a, cpha_a} = mode;
        start_a          = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
    endtask

    // Returns the cycle index (accept cycle = 0) in which done is seen; 200 means timeout.
    task automatic wait_done_a(output int lat);
        lat    = 0;
        cs_bad = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy_a && cs_n_a !== cs_exp) cs_bad++;
            if (lat == poke_at) begin
                start_a = 1'b1;
                tx_a    = 8'h99;
                cpol_a  = ~cpol_a;
                cpha_a  = ~cpha_a;
            end else begin
                start_a = 1'b0;
            end
            if (done_a) break;
        end
        if (done_a && b2b) begin
            tx_a             = b2b_tx;
            {cpol_a, cpha_a} = b2b_mode;
            start_a          = 1'b1;
        end
    endtask

    logic [7:0] pats [4];
    int lat;
    int extra;
    int cs_bad_b;
    logic busy_seen;

    initial begin
        pats[0] = 8'hAA;
        pats[1] = 8'h55;
        pats[2] = 8'h0F;
        pats[3] = 8'hFF;
        rst = 1'b0;
        start_a = 1'b0; tx_a = 8'h00; cs_a = 2'd0; cpol_a = 1'b0; cpha_a = 1'b0;
        start_b = 1'b0; tx_b = 16'h0; cs_b = 2'd0; cpol_b = 1'b0; cpha_b = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        lsb_a = 1'b0;
        lsb_b = 1'b0;
`endif

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_sclk", sclk_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_cs_n", cs_n_a, 4'hF);
        check("rst_rx", rx_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_cs_n_b", cs_n_b, 2'b11);
        rst = 1'b1;
        @(negedge clk);

        // Loopback in all four modes on cs_sel=1
        for (int m = 0; m < 4; m++) begin
            launch_a(pats[m], 2'd1, 2'(m));
            wait_done_a(lat);
            check($sformatf("lb_lat_m%0d", m), lat, 37);
            check($sformatf("lb_rx_m%0d", m), rx_a, pats[m]);
            check($sformatf("lb_cs_m%0d", m), cs_bad, 0);
            check($sformatf("lb_cs_idle_m%0d", m), cs_n_a, 4'hF);
            check($sformatf("lb_sclk_idle_m%0d", m), sclk_a, (m >> 1) & 1);
        end

        // Mode-3 slave returning C3; sclk idles high around it
        check("slv_sclk_before", sclk_a, 1);
        slave_en = 1'b1;
        launch_a(8'h00, 2'd1, Mode3);
        wait_done_a(lat);
        slave_en = 1'b0;
        check("slv_lat", lat, 37);
        check("slv_rx", rx_a, 8'hC3);
        check("slv_sclk_after", sclk_a, 1);

        // start while busy (with tx/cpol/cpha also changing) must be ignored
        launch_a(8'h3C, 2'd1, Mode0);
        poke_at = 10;
        wait_done_a(lat);
        poke_at = 0;
        check("busy_lat", lat, 37);
        check("busy_rx", rx_a, 8'h3C);
        check("busy_sclk_idle", sclk_a, 0);
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_a) extra++;
        end
        check("busy_extra_done", extra, 0);
        check("busy_idle", busy_a, 0);

        // start in the done cycle starts the next transfer immediately
        b2b      = 1'b1;
        b2b_tx   = 8'h5A;
        b2b_mode = Mode1;
        launch_a(8'hC6, 2'd1, Mode2);
        wait_done_a(lat);
        b2b = 1'b0;
        check("b2b_first_rx", rx_a, 8'hC6);
        @(posedge clk);
        #1 start_a = 1'b0;
        @(negedge clk);
        check("b2b_busy", busy_a, 1);
        check("b2b_cs_n", cs_n_a, 4'b1101);
        wait_done_a(lat);
        check("b2b_lat", lat, 36);
        check("b2b_rx", rx_a, 8'h5A);

        // Reset mid-transfer
        launch_a(8'hAA, 2'd1, Mode2);
        repeat (12) @(negedge clk);
        check("mid_busy_pre", busy_a, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_sclk", sclk_a, 0);
        check("mid_cs_n", cs_n_a, 4'hF);
        check("mid_busy", busy_a, 0);
        check("mid_done", done_a, 0);
        check("mid_rx", rx_a, 0);
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_a) extra++;
        end
        check("mid_no_done", extra, 0);

        // Instance B: 16-bit, CLK_DIV=1, cs_sel out of range
        @(negedge clk);
        tx_b    = 16'hA5C3;
        cs_b    = 2'd3;
        cpol_b  = 1'b0;
        cpha_b  = 1'b1;
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        lat       = 0;
        cs_bad_b  = 0;
        busy_seen = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) busy_seen = busy_b;
            if (cs_n_b !== 2'b11) cs_bad_b++;
            if (done_b) break;
        end
        check("b_busy", busy_seen, 1);
        check("b_lat", lat, 35);
        check("b_cs_n", cs_bad_b, 0);
        check("b_rx", rx_b, 16'hA5C3);

`ifdef SPI_LSB_FIRST_EN
        // LSB-first: first mosi bit is bit 0, loopback returns natural order
        @(negedge clk);
        tx_a    = 8'h01;
        cs_a    = 2'd1;
        cpol_a  = 1'b0;
        cpha_a  = 1'b0;
        lsb_a   = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        @(negedge clk);
        check("lsb_first_bit", mosi_a, 1);
        wait_done_a(lat);
        lsb_a = 1'b0;
        check("lsb_lat", lat, 36);
        check("lsb_rx", rx_a, 8'h01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised successor to the fixed 8-bit, mode-0, single-slave SPI master used in spi_top.
- Supports configurable word width, programmable SCLK divider, all four CPOL/CPHA modes selected per transfer, and NUM_CS active-low chip selects.
- Sits between a local start/data handshake and the external 4-wire SPI pins; full-duplex, one word per transfer.

Parameters:
- DATA_W, 8: bits per transfer (>=2).
- NUM_CS, 4: number of chip-select outputs (>=1).
- CLK_DIV, 4: clk cycles per SCLK half-period (>=1).
- CS_W, $clog2(NUM_CS) (min 1): width of cs_sel.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request transfer; sampled only when busy=0.
- tx_data  in  DATA_W  word to transmit.
- cs_sel  in  CS_W  target slave index.
- cpol  in  1  SCLK idle level for this transfer.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- miso  in  1  serial input from slave.
- sclk  out  1  serial clock.
- mosi  out  1  serial output to slave.
- cs_n  out  NUM_CS  active-low chip selects.
- rx_data  out  DATA_W  last received word.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when rx_data is valid.

Behaviour:
- Reset (rst=0, async): state IDLE; sclk=0, mosi=0, cs_n all 1, rx_data=0, busy=0, done=0; divider and bit counters cleared.
- Divider: counts 0..CLK_DIV-1 in SETUP, XFER and HOLD. Wrap is a "tick" and ends a half-period.
- IDLE:
  - sclk = latched cpol (initially 0 after reset).
  - On start=1: latch tx_data, cs_sel, cpol, cpha. Next cycle enters SETUP with busy=1 and cs_n[cs_sel]=0.
- SETUP: one half-period.
  - sclk = cpol.
  - CPHA=0: mosi = first bit on entry.
  - CPHA=1: mosi holds its previous value.
  - Tick -> XFER.
- XFER: 2*DATA_W half-periods; sclk toggles at each tick. Odd edges are leading, even edges trailing.
  - CPHA=0: sample miso on leading edges; shift next bit onto mosi on trailing edges, except the final edge.
  - CPHA=1: drive next bit on leading edges; sample on trailing edges.
  - After edge 2*DATA_W, sclk equals cpol -> HOLD.
- HOLD: one half-period, cs_n held low. Tick -> cs_n all 1, rx_data loaded, done=1 for one cycle, busy=0, state IDLE.
- Bit order: MSB first (see Optional Feature).
- Latency: with the start-accept cycle counted as 0, done is high in cycle 1 + CLK_DIV*(2*DATA_W+2). Example: DATA_W=8, CLK_DIV=2 gives cycle 37.
- Boundary conditions:
  - start while busy=1: ignored, no queuing.
  - start in the same cycle as done: accepted; the new transfer starts the next cycle.
  - cs_sel >= NUM_CS: transfer runs with all cs_n high, rx_data still updated.
  - CLK_DIV=1: every cycle is a tick.
  - Reset mid-transfer: immediate return to reset values; no done pulse.
  - tx_data/cpol/cpha changing during a transfer: no effect.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: adds input port lsb_first (1 bit), latched with start. When 1, bit 0 is shifted out first and received bits fill from the MSB end, so rx_data is in natural order.
- Undefined: no lsb_first port; always MSB first.

Decomposition:
- Package spi_pkg: state enum (IDLE, SETUP, XFER, HOLD); mode encodings MODE0..MODE3 = {cpol,cpha}.
- One sub-module, spi_clk_div: CLK_DIV counter with enable, producing tick and the edge index.
- Shift register and FSM live in spi_master_param.

Test Plan:
- Reset: assert rst=0 mid-transfer at DATA_W=8 -> sclk=0, cs_n=4'b1111, busy=0, no done pulse.
- Loopback mosi->miso, CLK_DIV=2, cs_sel=1, all four modes, tx_data 8'hAA, 8'h55, 8'h0F, 8'hFF -> rx_data equals tx_data; done in cycle 37; only cs_n[1] low.
- Slave model returning 8'hC3 in mode 3 -> rx_data=8'hC3; sclk idles high before and after.
- start pulsed again while busy -> ignored, exactly one done. start in the done cycle -> back-to-back transfer begins the next cycle.
- DATA_W=16, CLK_DIV=1, NUM_CS=2, cs_sel=3 -> all cs_n high, done in cycle 35.
- With SPI_LSB_FIRST_EN, lsb_first=1, tx_data 8'h01 -> first mosi bit is 1; loopback rx_data=8'h01.
